// File: rtl/sand_mem_pkg.sv
// Shared constants and types for the SDRAM arbiter: requester ids, FSM states
// and a saturating counter helper.
package sand_mem_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int NREQ   = 3;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_VGA  = 2'd0;
    localparam req_id_t REQ_PHYS = 2'd1;
    localparam req_id_t REQ_HPS  = 2'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sand_tag_fifo.sv
// Tag FIFO that remembers which requester issued each outstanding read.
// Push and pop may occur in the same cycle.
module sand_tag_fifo
    import sand_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output req_id_t pop_id,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(DEPTH);

    req_id_t       slots [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_id  = slots[rd_ptr[PW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) slots[wr_ptr[PW-1:0]] <= push_id;
    end

endmodule

// File: rtl/sand_mem_arbiter.sv
// Arbitrates the single SDRAM Avalon-MM master between VGA, physics and HPS
// requesters; optional counters are enabled with SAND_MEM_ARB_STATS_EN.
module sand_mem_arbiter #(
    parameter int ADDR_W    = sand_mem_pkg::ADDR_W,
    parameter int DATA_W    = sand_mem_pkg::DATA_W,
    parameter int NREQ      = sand_mem_pkg::NREQ,
    parameter int MAX_OUTST = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_read,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ack,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [ADDR_W-1:0]        mem_address,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [DATA_W-1:0]        mem_writedata,
    input  logic                     mem_waitrequest,
    input  logic                     mem_readdatavalid,
    input  logic [DATA_W-1:0]        mem_readdata,
    output logic                     rsp_orphan
`ifdef SAND_MEM_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]       grant_cnt,
    output logic [15:0]              stall_cnt
`endif
);

    import sand_mem_pkg::*;

    arb_state_e      state;
    arb_state_e      next_state;
    req_id_t         owner;
    req_id_t         winner;
    req_id_t         rr_ptr;
    req_id_t         tag_id;
    logic            grant;
    logic            accept;
    logic            fifo_full;
    logic            fifo_empty;
    logic            tag_pop;
    logic [NREQ-1:0] elig;

    always_comb begin
        elig = '0;
        for (int r = 0; r < NREQ; r++) begin
            elig[r] = req_write[r] || (req_read[r] && !fifo_full);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // A set req_ack marks the bubble cycle: the acked request is still visible.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        if (elig[REQ_VGA])                        winner = REQ_VGA;
        else if (elig[REQ_PHYS] && elig[REQ_HPS]) winner = rr_ptr;
        else if (elig[REQ_PHYS])                  winner = REQ_PHYS;
        else                                      winner = REQ_HPS;
        case (state)
            IDLE: begin
                if (req_ack == '0 && elig != '0) begin
                    grant      = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_waitrequest) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept = (state == ISSUE) && !mem_waitrequest;

    always_ff @(posedge clock) begin
        if (reset) begin
            owner         <= REQ_VGA;
            rr_ptr        <= REQ_PHYS;
            mem_address   <= '0;
            mem_writedata <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            req_ack       <= '0;
        end else begin
            req_ack <= '0;
            if (grant) begin
                owner         <= winner;
                mem_address   <= req_addr[winner*ADDR_W +: ADDR_W];
                mem_writedata <= req_wdata[winner*DATA_W +: DATA_W];
                mem_write     <= req_write[winner];
                mem_read      <= !req_write[winner];
                if (winner != REQ_VGA) begin
                    rr_ptr <= (winner == REQ_PHYS) ? REQ_HPS : REQ_PHYS;
                end
            end
            if (accept) begin
                mem_read       <= 1'b0;
                mem_write      <= 1'b0;
                req_ack[owner] <= 1'b1;
            end
        end
    end

    sand_tag_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_tags (
        .clock   (clock),
        .reset   (reset),
        .push    (accept && mem_read),
        .push_id (owner),
        .pop     (tag_pop),
        .pop_id  (tag_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tag_pop = mem_readdatavalid && !fifo_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_orphan <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (tag_pop) begin
                rsp_valid[tag_id] <= 1'b1;
                rsp_data          <= mem_readdata;
            end
            if (mem_readdatavalid && fifo_empty) rsp_orphan <= 1'b1;
        end
    end

`ifdef SAND_MEM_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                grant_cnt[owner*16 +: 16] <= sat_inc16(grant_cnt[owner*16 +: 16]);
            end
            if (state == ISSUE && mem_waitrequest) stall_cnt <= sat_inc16(stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_sand_mem_arbiter.sv
// Bench for sand_mem_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of requests and read tags.
module tb_sand_mem_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int NR = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_read;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ack;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [AW-1:0]     mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [DW-1:0]     mem_writedata;
    logic              mem_waitrequest;
    logic              mem_readdatavalid;
    logic [DW-1:0]     mem_readdata;
    logic              rsp_orphan;
`ifdef SAND_MEM_ARB_STATS_EN
    logic [NR*16-1:0]  grant_cnt;
    logic [15:0]       stall_cnt;
`endif

    sand_mem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .NREQ      (NR),
        .MAX_OUTST (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_ack           (req_ack),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_readdata      (mem_readdata),
        .rsp_orphan        (rsp_orphan)
`ifdef SAND_MEM_ARB_STATS_EN
        ,
        .grant_cnt         (grant_cnt),
        .stall_cnt         (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Requester-side view: one pending request per client.
    bit            p_valid [3];
    bit            p_write [3];
    bit            hold    [3];
    logic [AW-1:0] p_addr  [3];
    logic [DW-1:0] p_data  [3];

    int            tagq [$];
    bit            cmd_active;
    bit            bubble;
    bit            exp_orphan;
    int            owner;
    int            pred;
    int            rr;
    int            g_cnt [3];
    int            stall_model;

    bit            rst_drv;
    bit            wait_drv;
    bit            rdv_drv;
    logic [DW-1:0] rdata_drv;

    int            n_checks;
    int            n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input int w);
        check({tag, "_read"},  mem_read,    !p_write[w]);
        check({tag, "_write"}, mem_write,   p_write[w]);
        check({tag, "_addr"},  mem_address, p_addr[w]);
        if (p_write[w]) check({tag, "_wdata"}, mem_writedata, p_data[w]);
    endtask

    // Drive inputs for the coming cycle and predict who should be granted in it.
    task automatic apply();
        bit e [3];
        reset             = rst_drv;
        mem_waitrequest   = wait_drv;
        mem_readdatavalid = rdv_drv;
        mem_readdata      = rdata_drv;
        for (int r = 0; r < 3; r++) begin
            req_read[r]            = p_valid[r] && !p_write[r];
            req_write[r]           = p_valid[r] && p_write[r];
            req_addr[r*AW +: AW]   = p_addr[r];
            req_wdata[r*DW +: DW]  = p_data[r];
            e[r] = p_valid[r] && (p_write[r] || tagq.size() < 4);
        end
        pred = -1;
        if (!rst_drv && !cmd_active && !bubble) begin
            if (e[0])              pred = 0;
            else if (e[1] && e[2]) pred = rr;
            else if (e[1])         pred = 1;
            else if (e[2])         pred = 2;
        end
        bubble = 1'b0;
    endtask

    task automatic tick();
        int id;
        @(posedge clock);
        #1;
        if (rst_drv) begin
            check("rst_mem_read",  mem_read, 0);
            check("rst_mem_write", mem_write, 0);
            check("rst_mem_addr",  mem_address, 0);
            check("rst_mem_wdata", mem_writedata, 0);
            check("rst_req_ack",   req_ack, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_data",  rsp_data, 0);
            check("rst_orphan",    rsp_orphan, 0);
            tagq.delete();
            cmd_active  = 1'b0;
            bubble      = 1'b0;
            exp_orphan  = 1'b0;
            rr          = 1;
            owner       = -1;
            stall_model = 0;
            for (int r = 0; r < 3; r++) g_cnt[r] = 0;
        end else begin
            if (rdv_drv && tagq.size() > 0) begin
                id = tagq.pop_front();
                check("rsp_valid", rsp_valid, 1 << id);
                check("rsp_data",  rsp_data, rdata_drv);
            end else begin
                if (rdv_drv) exp_orphan = 1'b1;
                check("rsp_quiet", rsp_valid, 0);
            end
            check("rsp_orphan", rsp_orphan, exp_orphan);
            if (cmd_active) begin
                if (wait_drv) begin
                    stall_model++;
                    check_cmd("cmd_hold", owner);
                    check("ack_hold", req_ack, 0);
                end else begin
                    check("cmd_release", {mem_read, mem_write}, 0);
                    check("req_ack", req_ack, 1 << owner);
                    if (!p_write[owner]) tagq.push_back(owner);
                    g_cnt[owner]++;
                    if (!hold[owner]) p_valid[owner] = 1'b0;
                    cmd_active = 1'b0;
                    bubble     = 1'b1;
                end
            end else if (pred >= 0) begin
                check_cmd("cmd_grant", pred);
                check("ack_grant", req_ack, 0);
                owner      = pred;
                cmd_active = 1'b1;
                if (pred == 1)      rr = 2;
                else if (pred == 2) rr = 1;
            end else begin
                check("bus_idle", {mem_read, mem_write}, 0);
                check("ack_idle", req_ack, 0);
            end
        end
    endtask

    task automatic step();
        apply();
        tick();
    endtask

    task automatic set_req(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_valid[r] = 1'b1;
        p_write[r] = wr;
        p_addr[r]  = a;
        p_data[r]  = d;
    endtask

    task automatic drain_reads();
        wait_drv = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 8 && tagq.size() > 0; i++) begin
            rdv_drv   = 1'b1;
            rdata_drv = DW'($urandom);
            step();
        end
        rdv_drv = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rr       = 1;
        owner    = -1;
        for (int r = 0; r < 3; r++) begin
            p_valid[r] = 1'b0;
            p_write[r] = 1'b0;
            hold[r]    = 1'b0;
            p_addr[r]  = '0;
            p_data[r]  = '0;
        end
        wait_drv  = 1'b0;
        rdv_drv   = 1'b0;
        rdata_drv = '0;

        rst_drv = 1'b1;
        step();
        step();
        rst_drv = 1'b0;

        // PHYS read returning 0xBEEF
        set_req(1, 1'b0, 24'h000050, 16'h0000);
        repeat (4) step();
        rdv_drv   = 1'b1;
        rdata_drv = 16'hBEEF;
        step();
        rdv_drv = 1'b0;
        step();

        // VGA and PHYS contend in the same cycle
        set_req(0, 1'b0, 24'h000100, 16'h0000);
        set_req(1, 1'b1, 24'h000200, 16'h0055);
        repeat (7) step();
        drain_reads();

        // PHYS and HPS writes held continuously
        hold[1] = 1'b1;
        hold[2] = 1'b1;
        set_req(1, 1'b1, 24'h000300, 16'h00A1);
        set_req(2, 1'b1, 24'h000400, 16'h00B2);
        repeat (12) step();
        hold[1] = 1'b0;
        hold[2] = 1'b0;
        repeat (9) step();

        // HPS write stalled by waitrequest for three cycles
        set_req(2, 1'b1, 24'h001234, 16'h00FF);
        wait_drv = 1'b1;
        repeat (4) step();
        wait_drv = 1'b0;
        repeat (3) step();

        // Fill the tag FIFO with VGA reads, then slip a PHYS write past it
        hold[0] = 1'b1;
        set_req(0, 1'b0, 24'h000800, 16'h0000);
        repeat (13) step();
        set_req(1, 1'b1, 24'h000900, 16'h0077);
        repeat (5) step();
        hold[0]   = 1'b0;
        rdv_drv   = 1'b1;
        rdata_drv = 16'h1357;
        step();
        rdv_drv = 1'b0;
        repeat (4) step();
        drain_reads();

        // Reset while a command is stalled with two reads outstanding
        set_req(1, 1'b0, 24'h0000A0, 16'h0000);
        repeat (3) step();
        set_req(2, 1'b0, 24'h0000B0, 16'h0000);
        repeat (3) step();
        set_req(0, 1'b0, 24'h0000C0, 16'h0000);
        wait_drv = 1'b1;
        repeat (2) step();
        for (int r = 0; r < 3; r++) p_valid[r] = 1'b0;
        rst_drv = 1'b1;
        step();
        rst_drv  = 1'b0;
        wait_drv = 1'b0;
        rdv_drv  = 1'b1;
        repeat (2) step();
        rdv_drv = 1'b0;
        step();
        check("orphan_after_reset", rsp_orphan, 1);

        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;

        // Random traffic
        repeat (3000) begin
            for (int r = 0; r < 3; r++) begin
                if (!p_valid[r] && $urandom_range(0, 3) == 0) begin
                    set_req(r, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
                end
            end
            wait_drv  = ($urandom_range(0, 9) < 3);
            rdv_drv   = (tagq.size() > 0) && ($urandom_range(0, 9) < 3);
            rdata_drv = DW'($urandom);
            step();
        end
        wait_drv = 1'b0;
        for (int i = 0; i < 60; i++) begin
            rdv_drv   = (tagq.size() > 0);
            rdata_drv = DW'($urandom);
            step();
        end
        rdv_drv = 1'b0;
        step();
        check("final_tags_empty", tagq.size(), 0);

`ifdef SAND_MEM_ARB_STATS_EN
        for (int r = 0; r < 3; r++) check("grant_cnt", grant_cnt[r*16 +: 16], g_cnt[r]);
        check("stall_cnt", stall_cnt, stall_model);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
